calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Control FSM for the calculator datapath. Consumes the single-cycle 5-bit key pulses produced by the input manager and builds two signed decimal operands. It latches the operator, sequences one shared ALU through a start/done handshake, and holds the value to be displayed. It sits between the input manager and the ALU/display driver, entirely in the 500 Hz `newClock` domain.

## Interface
- `DIGITS`, default 4: maximum decimal digits per operand.
- `WIDTH`, default 16: signed operand width; result width is 2*WIDTH.
- `TIMEOUT`, default 255: cycles to wait for `aluDone` before error.

Ports:
- `newClock` in 1: 500 Hz system clock; all pulses are synchronous to it.
- `resetN` in 1: reset, asynchronous assert, active-low.
- `numberPulse` in 5: bit4 is the valid flag; bits3:0 carry the digit 0–9.
- `operatorPulse` in 5: bit4 is the valid flag; bits3:0 are 4'hF (+), 4'hE (−) or 4'hD (×).
- `equalPulse`, `clearPulse`, `resetPulse`, `negativePulse` in 5: only bit4 is used.
- `aluStart` out 1: one-cycle request.
- `aluOp` out 2: 0 = add, 1 = sub, 2 = mul.
- `aluA`, `aluB` out WIDTH: signed operands.
- `aluDone` in 1: result-valid strobe.
- `aluResult` in 2*WIDTH: signed result.
- `displayValue` out 2*WIDTH: signed value to show.
- `errorFlag` out 1: high in ERROR.
- `busy` out 1: high in CALC.
- `state` out 3: current FSM state, for debug.

## Operation
- States: ENTER_A(0), ENTER_B(1), CALC(2), RESULT(3), ERROR(4).
- Digit entry (ENTER_A/ENTER_B):
  - On a digit ≤ 9 with count < DIGITS: mag = mag*10 + digit, count++.
  - Digits > 9, and any digit once count == DIGITS, are ignored.
- `negativePulse` toggles the sign of the operand currently being entered. It is ignored in CALC, RESULT and ERROR.
- Operator in ENTER_A:
  - Latch `aluOp`.
  - Clear B (mag, sign, count).
  - Go to ENTER_B.
- Operator in ENTER_B:
  - count == 0: replace the latched op.
  - count > 0: ignored.
- Equal in ENTER_B with count > 0: go to CALC and assert `aluStart`. Equal is ignored in every other case.
- CALC:
  - Wait for `aluDone`.
  - On `aluDone`, latch `aluResult` and go to RESULT.
  - After TIMEOUT cycles without `aluDone`, go to ERROR.
  - `aluDone` outside CALC is ignored.
- RESULT:
  - Digit: clear all, A = digit, go to ENTER_A.
  - Operator with |result| ≤ 10^DIGITS−1: A = result, latch op, clear B, go to ENTER_B.
  - Operator with |result| > 10^DIGITS−1: go to ERROR.
- `clearPulse`:
  - In ENTER_A/ENTER_B: zeroes the current operand only.
  - In RESULT/ERROR: full clear, go to ENTER_A.
  - In CALC: ignored.
- `resetPulse`: synchronous full clear to ENTER_A from any state, including CALC.
- Simultaneous pulses, priority: reset > clear > equal > operator > negative > number. Only the highest-priority pulse acts; the rest are dropped.
- `displayValue`:
  - ENTER_A: signed A.
  - ENTER_B: A while B count == 0, else signed B.
  - CALC: unchanged.
  - RESULT: result.
  - ERROR: 0.

## Timing
- Inputs are sampled on the rising `newClock` edge; all outputs are registered and reflect an input one cycle later.
- `aluStart` is high for exactly the first CALC cycle.
- `aluA`, `aluB` and `aluOp` are stable from that cycle until CALC is left.
- `aluDone` is honoured at the earliest one cycle after `aluStart`.
- The timeout counter starts at 0 on CALC entry.
- `resetN` low: immediately state = ENTER_A, all operands, counts, signs and `displayValue` = 0, `aluStart` = 0, `aluOp` = 0, `errorFlag` = 0, `busy` = 0. This applies mid-CALC too; a late `aluDone` is then ignored.
- `resetPulse` produces the same values on the next edge.

## Structure
- Shared package `calc_pkg` holds:
  - state encodings;
  - `aluOp` codes;
  - key codes 4'hF/4'hE/4'hD;
  - default DIGITS and TIMEOUT;
  - the 10^DIGITS−1 limit constant.
- Sub-module `operand_accumulator`: sign, magnitude, digit count, with digit/negate/clear/load controls. Instantiated twice, once for A and once for B.

## Test plan
- Digits 1, 2, then +, then 7, then =; ALU returns 19 after 3 cycles → `aluStart` one cycle with A=12, B=7, op=0; then RESULT with `displayValue`=19.
- Digits 1, 2, 3, 4, 5 → A=1234, count=4; the fifth digit is ignored.
- 5, negative, −, 3, = → `aluA`=−5, `aluB`=3, op=1; ALU returns −8 → `displayValue`=−8.
- From RESULT 19: +, 1, = → A=19, B=1; result 20 shown.
- Enter 12+7= and withhold `aluDone` → after 255 CALC cycles, ERROR with `errorFlag`=1 and `displayValue`=0; then clear → ENTER_A, all zero.
- `resetN` pulsed low during CALC → outputs at reset values asynchronously; an `aluDone` one cycle later leaves state at ENTER_A.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings and limits for the calculator control path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package calc_pkg;

    typedef enum logic [2:0] {
        S_ENTER_A = 3'd0,
        S_ENTER_B = 3'd1,
        S_CALC    = 3'd2,
        S_RESULT  = 3'd3,
        S_ERROR   = 3'd4
    } calcState_t;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;

    localparam logic [3:0] KEY_PLUS  = 4'hF;
    localparam logic [3:0] KEY_MINUS = 4'hE;
    localparam logic [3:0] KEY_TIMES = 4'hD;

    localparam int DEFAULT_DIGITS  = 4;
    localparam int DEFAULT_WIDTH   = 16;
    localparam int DEFAULT_TIMEOUT = 255;

    // Largest magnitude representable with the given number of decimal digits.
    function automatic longint maxMagnitude(input int digits);
        longint m;
        m = 1;
        for (int i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

    localparam longint MAX_MAGNITUDE = maxMagnitude(DEFAULT_DIGITS);

    // Maps an operator key code to {valid, aluOp}; unknown codes come back invalid.
    function automatic logic [2:0] decodeKey(input logic [3:0] key);
        case (key)
            KEY_PLUS:  return {1'b1, ALU_ADD};
            KEY_MINUS: return {1'b1, ALU_SUB};
            KEY_TIMES: return {1'b1, ALU_MUL};
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/operand_accumulator.sv
// Sign/magnitude decimal operand built one digit at a time.
// Latency: controls take effect on the next newClock edge; value is a registered decode.
// Backpressure: none; digits beyond DIGITS or above 9 are silently dropped.
module operand_accumulator #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 16,
    parameter int CW     = $clog2(DIGITS + 1)
) (
    input  logic                    newClock,
    input  logic                    resetN,
    input  logic                    clear,
    input  logic                    load,
    input  logic [WIDTH-1:0]        loadMag,
    input  logic                    loadNeg,
    input  logic [CW-1:0]           loadCount,
    input  logic                    negate,
    input  logic                    digitVld,
    input  logic [3:0]              digit,
    output logic signed [WIDTH-1:0] value,
    output logic [CW-1:0]           count
);

    localparam logic [CW-1:0] FULL = CW'(DIGITS);

    logic [WIDTH-1:0] mag;
    logic             neg;

    // Operand registers: clear beats load beats editing.
    always_ff @(posedge newClock or negedge resetN) begin
        if (!resetN) begin
            mag   <= '0;
            neg   <= 1'b0;
            count <= '0;
        end else if (clear) begin
            mag   <= '0;
            neg   <= 1'b0;
            count <= '0;
        end else if (load) begin
            mag   <= loadMag;
            neg   <= loadNeg;
            count <= loadCount;
        end else begin
            if (negate) begin
                neg <= ~neg;
            end
            if (digitVld && (digit <= 4'd9) && (count < FULL)) begin
                mag   <= WIDTH'(mag * WIDTH'(10) + WIDTH'(digit));
                count <= count + CW'(1);
            end
        end
    end

    assign value = neg ? -$signed(mag) : $signed(mag);

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control FSM: builds operands from key pulses and sequences one shared ALU.
// Latency: outputs reflect a key pulse one newClock later; aluStart lasts one CALC cycle.
// Backpressure: none; keys are dropped when meaningless, ALU waited on up to TIMEOUT cycles.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS  = DEFAULT_DIGITS,
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      newClock,
    input  logic                      resetN,
    input  logic [4:0]                numberPulse,
    input  logic [4:0]                operatorPulse,
    input  logic [4:0]                equalPulse,
    input  logic [4:0]                clearPulse,
    input  logic [4:0]                resetPulse,
    input  logic [4:0]                negativePulse,
    output logic                      aluStart,
    output logic [1:0]                aluOp,
    output logic signed [WIDTH-1:0]   aluA,
    output logic signed [WIDTH-1:0]   aluB,
    input  logic                      aluDone,
    input  logic signed [2*WIDTH-1:0] aluResult,
    output logic signed [2*WIDTH-1:0] displayValue,
    output logic                      errorFlag,
    output logic                      busy,
    output logic [2:0]                state
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] LIMIT = RW'(maxMagnitude(DIGITS));

    calcState_t curState, nextState;

    logic [1:0]           opReg;
    logic signed [RW-1:0] resultReg;
    logic [TW-1:0]        timer;
    logic                 startNext;
    logic                 opLoad, opClear, resultLoad, resultClear;

    logic                 aClear, aLoad, aNeg, aDigit;
    logic                 bClear, bNeg, bDigit;
    logic [WIDTH-1:0]     aLoadMag;
    logic                 aLoadNeg;
    logic [CW-1:0]        aLoadCount;
    logic signed [WIDTH-1:0] aValue, bValue;
    logic [CW-1:0]        aCount, bCount;

    logic [2:0]           keyInfo;
    logic                 digitOk;
    logic [RW-1:0]        absResult;
    logic                 unusedKeyBits;

    assign keyInfo   = decodeKey(operatorPulse[3:0]);
    assign digitOk   = numberPulse[3:0] <= 4'd9;
    assign absResult = resultReg[RW-1] ? RW'(-resultReg) : RW'(resultReg);
    assign unusedKeyBits = ^{equalPulse[3:0], clearPulse[3:0], resetPulse[3:0], negativePulse[3:0]};

    operand_accumulator #(.DIGITS(DIGITS), .WIDTH(WIDTH), .CW(CW)) accA (
        .newClock (newClock),
        .resetN   (resetN),
        .clear    (aClear),
        .load     (aLoad),
        .loadMag  (aLoadMag),
        .loadNeg  (aLoadNeg),
        .loadCount(aLoadCount),
        .negate   (aNeg),
        .digitVld (aDigit),
        .digit    (numberPulse[3:0]),
        .value    (aValue),
        .count    (aCount)
    );

    operand_accumulator #(.DIGITS(DIGITS), .WIDTH(WIDTH), .CW(CW)) accB (
        .newClock (newClock),
        .resetN   (resetN),
        .clear    (bClear),
        .load     (1'b0),
        .loadMag  ('0),
        .loadNeg  (1'b0),
        .loadCount('0),
        .negate   (bNeg),
        .digitVld (bDigit),
        .digit    (numberPulse[3:0]),
        .value    (bValue),
        .count    (bCount)
    );

    // Next-state and control decode; only the highest-priority pulse present is considered.
    always_comb begin
        nextState   = curState;
        startNext   = 1'b0;
        opLoad      = 1'b0;
        opClear     = 1'b0;
        resultLoad  = 1'b0;
        resultClear = 1'b0;
        aClear      = 1'b0;
        aLoad       = 1'b0;
        aNeg        = 1'b0;
        aDigit      = 1'b0;
        bClear      = 1'b0;
        bNeg        = 1'b0;
        bDigit      = 1'b0;
        aLoadMag    = '0;
        aLoadNeg    = 1'b0;
        aLoadCount  = '0;

        if (resetPulse[4]) begin
            aClear      = 1'b1;
            bClear      = 1'b1;
            opClear     = 1'b1;
            resultClear = 1'b1;
            nextState   = S_ENTER_A;
        end else begin
            case (curState)
                S_ENTER_A: begin
                    if (clearPulse[4]) begin
                        aClear = 1'b1;
                    end else if (equalPulse[4]) begin
                        // no second operand yet: equal is swallowed
                    end else if (operatorPulse[4]) begin
                        if (keyInfo[2]) begin
                            opLoad    = 1'b1;
                            bClear    = 1'b1;
                            nextState = S_ENTER_B;
                        end
                    end else if (negativePulse[4]) begin
                        aNeg = 1'b1;
                    end else if (numberPulse[4]) begin
                        aDigit = 1'b1;
                    end
                end
                S_ENTER_B: begin
                    if (clearPulse[4]) begin
                        bClear = 1'b1;
                    end else if (equalPulse[4]) begin
                        if (bCount != '0) begin
                            startNext = 1'b1;
                            nextState = S_CALC;
                        end
                    end else if (operatorPulse[4]) begin
                        // operator may be corrected until B gets its first digit
                        if (keyInfo[2] && (bCount == '0)) begin
                            opLoad = 1'b1;
                        end
                    end else if (negativePulse[4]) begin
                        bNeg = 1'b1;
                    end else if (numberPulse[4]) begin
                        bDigit = 1'b1;
                    end
                end
                S_CALC: begin
                    // a done in the aluStart cycle cannot belong to this request
                    if (aluDone && !aluStart) begin
                        resultLoad = 1'b1;
                        nextState  = S_RESULT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        nextState = S_ERROR;
                    end
                end
                S_RESULT: begin
                    if (clearPulse[4]) begin
                        aClear      = 1'b1;
                        bClear      = 1'b1;
                        opClear     = 1'b1;
                        resultClear = 1'b1;
                        nextState   = S_ENTER_A;
                    end else if (equalPulse[4]) begin
                        // repeat-equal is not supported
                    end else if (operatorPulse[4]) begin
                        if (keyInfo[2]) begin
                            if (absResult <= LIMIT) begin
                                aLoad      = 1'b1;
                                aLoadMag   = WIDTH'(absResult);
                                aLoadNeg   = resultReg[RW-1];
                                aLoadCount = CW'(DIGITS);
                                opLoad     = 1'b1;
                                bClear     = 1'b1;
                                nextState  = S_ENTER_B;
                            end else begin
                                nextState = S_ERROR;
                            end
                        end
                    end else if (negativePulse[4]) begin
                        // result sign is not editable
                    end else if (numberPulse[4]) begin
                        if (digitOk) begin
                            aLoad       = 1'b1;
                            aLoadMag    = WIDTH'(numberPulse[3:0]);
                            aLoadCount  = CW'(1);
                            bClear      = 1'b1;
                            opClear     = 1'b1;
                            resultClear = 1'b1;
                            nextState   = S_ENTER_A;
                        end
                    end
                end
                S_ERROR: begin
                    if (clearPulse[4]) begin
                        aClear      = 1'b1;
                        bClear      = 1'b1;
                        opClear     = 1'b1;
                        resultClear = 1'b1;
                        nextState   = S_ENTER_A;
                    end
                end
                default: nextState = S_ENTER_A;
            endcase
        end
    end

    // State, latched operator/result, ALU start strobe and CALC timeout counter.
    always_ff @(posedge newClock or negedge resetN) begin
        if (!resetN) begin
            curState  <= S_ENTER_A;
            opReg     <= ALU_ADD;
            resultReg <= '0;
            aluStart  <= 1'b0;
            timer     <= '0;
        end else begin
            curState <= nextState;
            aluStart <= startNext;
            timer    <= (curState == S_CALC) ? timer + TW'(1) : '0;
            if (opClear) begin
                opReg <= ALU_ADD;
            end else if (opLoad) begin
                opReg <= keyInfo[1:0];
            end
            if (resultClear) begin
                resultReg <= '0;
            end else if (resultLoad) begin
                resultReg <= aluResult;
            end
        end
    end

    // Display selection; in CALC the operand B shown on entry stays visible.
    always_comb begin
        displayValue = '0;
        case (curState)
            S_ENTER_A: displayValue = RW'(aValue);
            S_ENTER_B: displayValue = (bCount == '0) ? RW'(aValue) : RW'(bValue);
            S_CALC:    displayValue = RW'(bValue);
            S_RESULT:  displayValue = resultReg;
            default:   displayValue = '0;
        endcase
    end

    assign aluOp     = opReg;
    assign aluA      = aValue;
    assign aluB      = bValue;
    assign state     = curState;
    assign busy      = (curState == S_CALC);
    assign errorFlag = (curState == S_ERROR);

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;

    localparam int DIGITS  = 4;
    localparam int TIMEOUT = 255;
    localparam int LIMIT   = 9999;
    localparam int ST_A = 0, ST_B = 1, ST_CALC = 2, ST_RES = 3, ST_ERR = 4;

    logic newClock = 1'b0;
    logic resetN   = 1'b0;
    logic [4:0] numberPulse, operatorPulse, equalPulse, clearPulse, resetPulse, negativePulse;
    logic aluStart;
    logic [1:0] aluOp;
    logic signed [15:0] aluA, aluB;
    logic aluDone;
    logic signed [31:0] aluResult;
    logic signed [31:0] displayValue;
    logic errorFlag, busy;
    logic [2:0] state;

    always #5 newClock = ~newClock;

    calc_sequencer dut (
        .newClock(newClock), .resetN(resetN),
        .numberPulse(numberPulse), .operatorPulse(operatorPulse),
        .equalPulse(equalPulse), .clearPulse(clearPulse),
        .resetPulse(resetPulse), .negativePulse(negativePulse),
        .aluStart(aluStart), .aluOp(aluOp), .aluA(aluA), .aluB(aluB),
        .aluDone(aluDone), .aluResult(aluResult),
        .displayValue(displayValue), .errorFlag(errorFlag), .busy(busy), .state(state)
    );

    // Behavioural model: operands as plain integers with a sign flag.
    int mSt, aMag, bMag, aCnt, bCnt, mOp, mCalcCyc;
    bit aNeg, bNeg, mStart;
    longint mRes, mDisp;
    int aluDelay;
    bit aluWithhold, extraDone;
    int checks = 0;
    int errors = 0;
    logic [3:0] opKeys [3] = '{4'hF, 4'hE, 4'hD};

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint sval(input int mag, input bit neg);
        return neg ? -longint'(mag) : longint'(mag);
    endfunction

    function automatic int keyToOp(input logic [3:0] k);
        case (k)
            4'hF: return 0;
            4'hE: return 1;
            4'hD: return 2;
            default: return -1;
        endcase
    endfunction

    task automatic modelClear();
        mSt = ST_A; aMag = 0; aNeg = 0; aCnt = 0; bMag = 0; bNeg = 0; bCnt = 0;
        mOp = 0; mRes = 0; mCalcCyc = 0; mStart = 0;
    endtask

    task automatic addDigit(inout int mag, inout int cnt, input int d);
        if (d <= 9 && cnt < DIGITS) begin
            mag = mag * 10 + d;
            cnt++;
        end
    endtask

    task automatic modelStep();
        bit cp, ep, op, np, dp;
        int dig, k;
        longint absRes;
        cp = clearPulse[4]; ep = equalPulse[4]; op = operatorPulse[4];
        np = negativePulse[4]; dp = numberPulse[4];
        dig = int'(numberPulse[3:0]);
        k = keyToOp(operatorPulse[3:0]);
        mStart = 0;
        if (resetPulse[4]) modelClear();
        else case (mSt)
            ST_A: begin
                if (cp) begin aMag = 0; aNeg = 0; aCnt = 0; end
                else if (ep) ;
                else if (op) begin
                    if (k >= 0) begin mOp = k; bMag = 0; bNeg = 0; bCnt = 0; mSt = ST_B; end
                end
                else if (np) aNeg = !aNeg;
                else if (dp) addDigit(aMag, aCnt, dig);
            end
            ST_B: begin
                if (cp) begin bMag = 0; bNeg = 0; bCnt = 0; end
                else if (ep) begin
                    if (bCnt > 0) begin mSt = ST_CALC; mStart = 1; mCalcCyc = 0; end
                end
                else if (op) begin
                    if (bCnt == 0 && k >= 0) mOp = k;
                end
                else if (np) bNeg = !bNeg;
                else if (dp) addDigit(bMag, bCnt, dig);
            end
            ST_CALC: begin
                if (aluDone && mCalcCyc >= 1) begin mRes = longint'(aluResult); mSt = ST_RES; end
                else if (mCalcCyc + 1 >= TIMEOUT) mSt = ST_ERR;
                else mCalcCyc++;
            end
            ST_RES: begin
                absRes = (mRes < 0) ? -mRes : mRes;
                if (cp) modelClear();
                else if (ep || (op && k < 0)) ;
                else if (op) begin
                    if (absRes <= LIMIT) begin
                        aMag = int'(absRes); aNeg = (mRes < 0); aCnt = DIGITS;
                        mOp = k; bMag = 0; bNeg = 0; bCnt = 0; mSt = ST_B;
                    end else mSt = ST_ERR;
                end
                else if (np) ;
                else if (dp && dig <= 9) begin
                    modelClear(); aMag = dig; aCnt = 1;
                end
            end
            default: if (cp) modelClear();
        endcase
        case (mSt)
            ST_A:    mDisp = sval(aMag, aNeg);
            ST_B:    mDisp = (bCnt == 0) ? sval(aMag, aNeg) : sval(bMag, bNeg);
            ST_RES:  mDisp = mRes;
            ST_ERR:  mDisp = 0;
            default: ;
        endcase
    endtask

    task automatic checkAll();
        chk("state", state, mSt);
        chk("display", displayValue, mDisp);
        chk("aluStart", aluStart, mStart);
        chk("errorFlag", errorFlag, mSt == ST_ERR);
        chk("busy", busy, mSt == ST_CALC);
        chk("aluOp", aluOp, mOp);
        if (mSt == ST_CALC) begin
            chk("aluA", aluA, sval(aMag, aNeg));
            chk("aluB", aluB, sval(bMag, bNeg));
        end
    endtask

    task automatic clearInputs();
        numberPulse = '0; operatorPulse = '0; equalPulse = '0;
        clearPulse = '0; resetPulse = '0; negativePulse = '0;
        extraDone = 0;
    endtask

    // One cycle: drive the ALU, step model on the edge, compare on the falling edge.
    task automatic tick();
        longint r;
        if (mSt == ST_CALC) begin
            case (mOp)
                0: r = sval(aMag, aNeg) + sval(bMag, bNeg);
                1: r = sval(aMag, aNeg) - sval(bMag, bNeg);
                default: r = sval(aMag, aNeg) * sval(bMag, bNeg);
            endcase
            aluResult = 32'(r);
            aluDone = !aluWithhold && (mCalcCyc == aluDelay);
        end else begin
            aluResult = $urandom;
            aluDone = extraDone;
        end
        @(posedge newClock);
        modelStep();
        @(negedge newClock);
        checkAll();
        clearInputs();
    endtask

    task automatic digit(input int d);  numberPulse   = {1'b1, 4'(d)}; tick(); endtask
    task automatic oper(input logic [3:0] k); operatorPulse = {1'b1, k}; tick(); endtask
    task automatic eq();    equalPulse    = 5'h10; tick(); endtask
    task automatic neg();   negativePulse = 5'h10; tick(); endtask
    task automatic clr();   clearPulse    = 5'h10; tick(); endtask
    task automatic idle();  tick(); endtask
    task automatic waitCalc();
        for (int i = 0; i < 300; i++) begin
            if (mSt != ST_CALC) break;
            tick();
        end
    endtask

    task automatic randPulse();
        int r;
        r = $urandom_range(0, 99);
        if (r < 45)      numberPulse   = {1'b1, 4'($urandom_range(0, 11))};
        else if (r < 57) operatorPulse = {1'b1, opKeys[$urandom_range(0, 2)]};
        else if (r < 65) negativePulse[4] = 1'b1;
        else if (r < 77) equalPulse[4] = 1'b1;
        else if (r < 81) clearPulse[4] = 1'b1;
        else if (r < 82) resetPulse[4] = 1'b1;
    endtask

    initial begin
        int n;
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        clearInputs();
        aluDone = 0; aluResult = '0; aluDelay = 1; aluWithhold = 0;
        modelClear(); mDisp = 0;
        resetN = 0;
        repeat (2) @(negedge newClock);
        checkAll();
        chk("rst_aluA", aluA, 0);
        chk("rst_aluB", aluB, 0);
        resetN = 1;

        // 12 + 7 = 19 with done three cycles after start
        digit(1); digit(2); oper(4'hF); digit(7);
        aluDelay = 3; eq();
        chk("t1_start", aluStart, 1);
        chk("t1_A", aluA, 12);
        chk("t1_B", aluB, 7);
        chk("t1_op", aluOp, 0);
        idle();
        chk("t1_start_once", aluStart, 0);
        waitCalc();
        chk("t1_state", state, ST_RES);
        chk("t1_disp", displayValue, 19);

        // chain from result: 19 + 1 = 20
        oper(4'hF);
        chk("chain_state", state, ST_B);
        chk("chain_disp", displayValue, 19);
        eq();
        chk("eq_no_b_ignored", state, ST_B);
        digit(1); aluDelay = 1; eq();
        chk("chain_A", aluA, 19);
        chk("chain_B", aluB, 1);
        waitCalc();
        chk("chain_disp20", displayValue, 20);

        // digit limit
        clr();
        chk("full_clear", state, ST_A);
        digit(1); digit(2); digit(3); digit(4); digit(5);
        chk("digit_limit", displayValue, 1234);

        // -5 - 3 = -8
        clr();
        chk("clear_a", displayValue, 0);
        digit(5); neg();
        chk("neg_a", displayValue, -5);
        oper(4'hE); digit(3); aluDelay = 2; eq();
        chk("sub_A", aluA, -5);
        chk("sub_B", aluB, 3);
        chk("sub_op", aluOp, 1);
        waitCalc();
        chk("sub_disp", displayValue, -8);

        // priority: clear beats digit, negative beats digit, equal beats operator
        clearPulse = 5'h10; numberPulse = 5'h17; tick();
        chk("prio_clear", displayValue, 0);
        digit(4);
        negativePulse = 5'h10; numberPulse = 5'h15; tick();
        chk("prio_neg", displayValue, -4);
        equalPulse = 5'h10; operatorPulse = 5'h1F; tick();
        chk("prio_eq", state, ST_A);

        // magnitude limit: 9999 chains, 10000 errors; operator replacement
        clr(); digit(9); digit(9); oper(4'hF); oper(4'hD);
        digit(1); digit(0); digit(1); aluDelay = 1; eq();
        chk("replace_op", aluOp, 2);
        waitCalc();
        chk("max_disp", displayValue, 9999);
        oper(4'hF);
        chk("max_chain", state, ST_B);
        digit(1); eq(); waitCalc();
        chk("over_disp", displayValue, 10000);
        oper(4'hE);
        chk("over_state", state, ST_ERR);
        chk("over_err", errorFlag, 1);
        chk("over_disp0", displayValue, 0);
        clr();
        chk("err_clear", state, ST_A);

        // timeout
        digit(1); digit(2); oper(4'hF); digit(7);
        aluWithhold = 1; eq();
        n = 0;
        while (busy === 1'b1 && n < 400) begin tick(); n++; end
        chk("timeout_len", n, TIMEOUT);
        chk("timeout_state", state, ST_ERR);
        chk("timeout_err", errorFlag, 1);
        chk("timeout_disp", displayValue, 0);
        clr();
        chk("timeout_clear", state, ST_A);
        chk("timeout_clear_disp", displayValue, 0);
        aluWithhold = 0;

        // asynchronous reset mid-CALC, then a stale done
        digit(3); oper(4'hD); digit(4); aluWithhold = 1; eq(); idle();
        #2 resetN = 0;
        #1;
        chk("areset_state", state, ST_A);
        chk("areset_start", aluStart, 0);
        chk("areset_busy", busy, 0);
        chk("areset_disp", displayValue, 0);
        chk("areset_op", aluOp, 0);
        chk("areset_A", aluA, 0);
        chk("areset_err", errorFlag, 0);
        modelClear(); mDisp = 0;
        @(posedge newClock);
        @(negedge newClock);
        resetN = 1; aluWithhold = 0; extraDone = 1;
        tick();
        chk("late_done", state, ST_A);

        // randomized traffic against the model
        for (int it = 0; it < 3000; it++) begin
            numberPulse = {1'b0, 4'($urandom)};
            operatorPulse = {1'b0, 4'($urandom)};
            equalPulse = {1'b0, 4'($urandom)};
            clearPulse = {1'b0, 4'($urandom)};
            negativePulse = {1'b0, 4'($urandom)};
            randPulse();
            if ($urandom_range(0, 9) == 0) randPulse();
            if ($urandom_range(0, 19) == 0) extraDone = 1;
            tick();
            if (mStart) begin
                aluDelay = ($urandom_range(0, 49) == 0) ? 0 : $urandom_range(1, 6);
                aluWithhold = ($urandom_range(0, 39) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
